// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, opcodes and fetch FSM states
package mips_pkg;

  localparam int NB_ADDR_DEF = 32;
  localparam int NB_INST_DEF = 32;

  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_instr_mem.sv
// rtl/if_instr_mem.sv - word-addressed instruction memory, one sync write port, one async read port
// A read of the word being written in the same cycle returns the old contents.
module if_instr_mem #(
  parameter int NB_INST     = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = $clog2(MEM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [NB_MEM_ADDR-1:0] i_wr_addr,
  input  logic [NB_INST-1:0]     i_wr_data,
  input  logic [NB_MEM_ADDR-1:0] i_rd_addr,
  output logic [NB_INST-1:0]     o_rd_data
);

  logic [NB_INST-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, instruction memory, IF/ID register, redirects and HALT
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int NB_ADDR   = NB_ADDR_DEF,
  parameter int NB_INST   = NB_INST_DEF,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic                         i_stall,
  input  logic                         i_branch_taken,
  input  logic [NB_ADDR-1:0]           i_branch_target,
  input  logic                         i_jump,
  input  logic [NB_ADDR-1:0]           i_jump_target,
  input  logic                         i_mem_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_mem_wr_addr,
  input  logic [NB_INST-1:0]           i_mem_wr_data,
  output logic [NB_INST-1:0]           o_instruction,
  output logic [NB_ADDR-1:0]           o_pc,
  output logic                         o_valid,
  output logic                         o_halt,
  output logic [31:0]                  o_fetch_count,
  output logic [31:0]                  o_stall_count
);

  localparam int NB_MEM_ADDR = $clog2(MEM_DEPTH);

  fetch_state_t       state, state_nxt;
  logic [NB_ADDR-1:0] pc, pc_nxt, pc_plus4, redirect_target, opc_nxt;
  logic [NB_INST-1:0] fetched, instr_nxt;
  logic               redirect, valid_nxt, halt_nxt;

  if_instr_mem #(
    .NB_INST    (NB_INST),
    .MEM_DEPTH  (MEM_DEPTH),
    .NB_MEM_ADDR(NB_MEM_ADDR)
  ) u_imem (
    .i_clk    (i_clk),
    .i_wr_en  (i_mem_wr_en),
    .i_wr_addr(i_mem_wr_addr),
    .i_wr_data(i_mem_wr_data),
    .i_rd_addr(pc[NB_MEM_ADDR+1:2]),
    .o_rd_data(fetched)
  );

  assign pc_plus4        = pc + NB_ADDR'(4);
  assign redirect        = i_jump | i_branch_taken;
  assign redirect_target = (i_jump ? i_jump_target : i_branch_target) & ~NB_ADDR'(3);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = o_instruction;
    opc_nxt   = o_pc;
    valid_nxt = o_valid;
    halt_nxt  = o_halt;
    if (i_enable) begin
      case (state)
        ST_RUN: begin
          // Redirect wins over both a stall and a HALT word being fetched.
          if (redirect) begin
            pc_nxt    = redirect_target;
            instr_nxt = NB_INST'(NOP_INST);
            valid_nxt = 1'b0;
          end else if (!i_stall) begin
            instr_nxt = fetched;
            opc_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            if (fetched == NB_INST'(HALT_INST)) state_nxt = ST_HALT;
            else                                pc_nxt    = pc_plus4;
          end
        end
        ST_HALT: begin
          instr_nxt = NB_INST'(NOP_INST);
          valid_nxt = 1'b0;
          halt_nxt  = 1'b1;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc            <= '0;
      o_instruction <= NB_INST'(NOP_INST);
      o_pc          <= '0;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      o_instruction <= instr_nxt;
      o_pc          <= opc_nxt;
      o_valid       <= valid_nxt;
      o_halt        <= halt_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        count_fetch, count_stall;
  logic [31:0] fetch_cnt, stall_cnt;

  assign count_fetch = i_enable && (state == ST_RUN) && !redirect && !i_stall;
  assign count_stall = i_enable && (state == ST_RUN) && !redirect && i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (count_fetch) fetch_cnt <= fetch_cnt + 32'd1;
      if (count_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_fetch_count = fetch_cnt;
  assign o_stall_count = stall_cnt;
`else
  assign o_fetch_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, stall = 1'b0;
  logic        br = 1'b0, jmp = 1'b0, we = 1'b0;
  logic [31:0] bt = '0, jt = '0, wd = '0;
  logic [7:0]  wa = '0;
  logic [31:0] instr, opc, fcnt, scnt;
  logic        valid, halt;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_stall        (stall),
    .i_branch_taken (br),
    .i_branch_target(bt),
    .i_jump         (jmp),
    .i_jump_target  (jt),
    .i_mem_wr_en    (we),
    .i_mem_wr_addr  (wa),
    .i_mem_wr_data  (wd),
    .o_instruction  (instr),
    .o_pc           (opc),
    .o_valid        (valid),
    .o_halt         (halt),
    .o_fetch_count  (fcnt),
    .o_stall_count  (scnt)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] opc;
    logic        valid;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tb_mem [256];
  logic [31:0] prog [4];
  logic [31:0] m_instr, m_opc, m_pc, m_fetch, m_stall;
  logic        m_valid, m_halt_st, m_ohalt;
  int          checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = 32'h0; m_opc = 32'h0; m_pc = 32'h0; m_fetch = 32'h0; m_stall = 32'h0;
    m_valid = 1'b0; m_halt_st = 1'b0; m_ohalt = 1'b0;
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tb_mem[a] = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the predicted IF/ID state, then compare after the edge.
  task automatic cycle(input string tag, input logic e, input logic s,
                       input logic b, input logic [31:0] btg,
                       input logic j, input logic [31:0] jtg,
                       input logic w, input logic [7:0] wadr, input logic [31:0] wdat);
    exp_t        ex;
    logic [31:0] word;
    en = e; stall = s; br = b; bt = btg; jmp = j; jt = jtg; we = w; wa = wadr; wd = wdat;
    if (e) begin
      if (m_halt_st) begin
        m_instr = 32'h0; m_valid = 1'b0; m_ohalt = 1'b1;
      end else if (j || b) begin
        m_pc = (j ? jtg : btg) & 32'hFFFF_FFFC;
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (s) begin
        m_stall = m_stall + 1;
      end else begin
        word = tb_mem[m_pc[9:2]];
        m_instr = word; m_opc = m_pc + 4; m_valid = 1'b1; m_fetch = m_fetch + 1;
        if (word == 32'hFFFF_FFFF) m_halt_st = 1'b1;
        else                       m_pc = m_pc + 4;
      end
    end
    if (w) tb_mem[wadr] = wdat;
    ex.instr = m_instr; ex.opc = m_opc; ex.valid = m_valid; ex.halt = m_ohalt; ex.pc = m_pc;
`ifdef IF_PERF_CNT_EN
    ex.fcnt = m_fetch; ex.scnt = m_stall;
`else
    ex.fcnt = 32'h0; ex.scnt = 32'h0;
`endif
    sb.push_back(ex);
    @(posedge clk); #1;
    we = 1'b0;
    ex = sb.pop_front();
    check_eq({tag, ".instr"}, instr, ex.instr);
    check_eq({tag, ".opc"},   opc,   ex.opc);
    check_eq({tag, ".valid"}, {31'h0, valid}, {31'h0, ex.valid});
    check_eq({tag, ".halt"},  {31'h0, halt},  {31'h0, ex.halt});
    check_eq({tag, ".pc"},    dut.pc, ex.pc);
    check_eq({tag, ".fcnt"},  fcnt, ex.fcnt);
    check_eq({tag, ".scnt"},  scnt, ex.scnt);
  endtask

  task automatic run(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'hFFFF_FFFF;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.instr", instr, 32'h0);
    check_eq("rst.opc",   opc,   32'h0);
    check_eq("rst.valid", {31'h0, valid}, 32'h0);
    check_eq("rst.halt",  {31'h0, halt},  32'h0);
    check_eq("rst.fcnt",  fcnt, 32'h0);

    for (int i = 0; i < 256; i++)
      write_mem(8'(i), (i < 4) ? prog[i] : (32'h1000_0000 + 32'(i)));

    rst_n = 1'b1;
    run("fetch0");
    cycle("stall1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    cycle("stall2", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    check_eq("stall.instr", instr, 32'h2001_0005);
    check_eq("stall.opc",   opc,   32'h4);
`ifdef IF_PERF_CNT_EN
    check_eq("stall.cnt", scnt, 32'h2);
`endif
    run("fetch1");
    run("fetch2");
    check_eq("fetch2.instr", instr, 32'h0022_1820);
    run("fetch3");
    check_eq("halt_word", instr, 32'hFFFF_FFFF);
    check_eq("halt_late", {31'h0, halt}, 32'h0);
    cycle("halt1", 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    run("halt2");
    check_eq("halt.pc",   dut.pc, 32'hC);
    check_eq("halt.flag", {31'h0, halt}, 32'h1);

    rst_n = 1'b0;
    #1;
    check_eq("arst.valid", {31'h0, valid}, 32'h0);
    check_eq("arst.pc",    dut.pc, 32'h0);
    #2 rst_n = 1'b1;
    model_reset();

    run("r_fetch0");
    cycle("br_stall", 1'b1, 1'b1, 1'b1, 32'h23, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
    run("br_fetch");
    check_eq("br.opc",   opc,   32'h24);
    check_eq("br.instr", instr, 32'h1000_0008);
    cycle("jmp_br", 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 8'h0, 32'h0);
    run("jmp_fetch");
    check_eq("jmp.opc", opc, 32'h44);
    cycle("freeze", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 8'd17, 32'hCAFE_0011);
    run("frz_fetch");
    cycle("jmp_wrap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3FC, 1'b0, 8'h0, 32'h0);
    run("wrap255");
    check_eq("wrap.opc", opc, 32'h400);
    run("wrap0");
    check_eq("wrap0.instr", instr, 32'h2001_0005);
    cycle("collide", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd1, 32'hDEAD_BEEF);
    check_eq("collide.old", instr, 32'h2002_0003);
    cycle("jmp_back", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h404, 1'b0, 8'h0, 32'h0);
    run("new_word");
    check_eq("new_word.instr", instr, 32'hDEAD_BEEF);

    cycle("pend_jmp", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 8'h0, 32'h0);
    jmp = 1'b1; jt = 32'h100;
    rst_n = 1'b0;
    #1;
    check_eq("mrst.valid", {31'h0, valid}, 32'h0);
    check_eq("mrst.pc",    dut.pc, 32'h0);
    check_eq("mrst.instr", instr, 32'h0);
    check_eq("mrst.opc",   opc,   32'h0);
    #2 rst_n = 1'b1;
    model_reset();
    run("restart");
    check_eq("sb.empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
